// File: rtl/sm2201_interface_board.sv
// ISA I/O bus (8-bit) to SM2201 CAMAC controller (16-bit) bridge with wait-state and LAM/IRQ handling.
// Optional feature macro: SM2201_IRQ_EN (drives isa_irq[IRQ_LINE] from irq_en & prr_pending).
module sm2201_interface_board #(
    parameter logic [9:0] BASE_ADDR   = 10'h100,
    parameter int         WAIT_STATES = 2,
    parameter int         IRQ_LINE    = 5
) (
    input  logic        isa_clk,
    input  logic        isa_reset,
    input  logic        isa_ior,
    input  logic        isa_iow,
    input  logic [9:0]  isa_addr,
    input  logic        isa_ale,
    input  logic        isa_aen,
    inout  wire  [7:0]  isa_data,
    output logic        isa_chrdy,
    output logic [7:0]  isa_irq,
    input  logic        cb_prr,
    input  logic        cb_zk4,
    input  logic        cb_cx1,
    inout  wire  [15:0] cb_data
);

    localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_STATES);
    localparam logic [7:0] IRQ_MASK    = 8'h01 << IRQ_LINE;
    localparam logic [5:0] OFF_DATA_LO = 6'h00;
    localparam logic [5:0] OFF_DATA_HI = 6'h01;
    localparam logic [5:0] OFF_STATUS  = 6'h02;
    localparam logic [5:0] OFF_CONTROL = 6'h03;
    localparam logic [5:0] OFF_ACK     = 6'h04;

    logic [9:0]  r_addr_q;
    logic [2:0]  r_ior_sync;
    logic [2:0]  r_iow_sync;
    logic [2:0]  r_prr_sync;
    logic [2:0]  r_cx1_sync;
    logic [1:0]  r_zk4_sync;
    logic [15:0] r_rx;
    logic [15:0] r_tx;
    logic        r_valid;
    logic        r_prr_pending;
    logic        r_tx_drive;
    logic [3:0]  r_wait_cnt;
    logic        r_chrdy;
    logic [7:0]  r_irq;

    logic        w_sel;
    logic [5:0]  w_off;
    logic        w_ior_fall;
    logic        w_ior_rise;
    logic        w_iow_fall;
    logic        w_iow_rise;
    logic        w_cx1_fall;
    logic        w_prr_fall;
    logic        w_zk4_low;
    logic        w_wr;
    logic        w_rd_done;
    logic        w_irq_en;
    logic [7:0]  w_rd_data;
    logic [3:0]  w_wait_nxt;

    assign w_sel      = ~isa_aen & (r_addr_q[9:6] == BASE_ADDR[9:6]);
    assign w_off      = r_addr_q[5:0];
    // index [1] is the synchronized level, [2] its previous value
    assign w_ior_fall = r_ior_sync[2] & ~r_ior_sync[1];
    assign w_ior_rise = ~r_ior_sync[2] & r_ior_sync[1];
    assign w_iow_fall = r_iow_sync[2] & ~r_iow_sync[1];
    assign w_iow_rise = ~r_iow_sync[2] & r_iow_sync[1];
    assign w_cx1_fall = r_cx1_sync[2] & ~r_cx1_sync[1];
    assign w_prr_fall = r_prr_sync[2] & ~r_prr_sync[1];
    assign w_zk4_low  = ~r_zk4_sync[1];
    assign w_wr       = w_iow_rise & w_sel;
    assign w_rd_done  = w_ior_rise & w_sel;

`ifdef SM2201_IRQ_EN
    logic r_irq_en;

    // Interrupt enable bit of CONTROL
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_irq_en <= 1'b0;
        end else if (w_wr && (w_off == OFF_CONTROL)) begin
            r_irq_en <= isa_data[1];
        end
    end

    assign w_irq_en = r_irq_en;
`else
    assign w_irq_en = 1'b0;
`endif

    // Address latch and input synchronizers
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_addr_q   <= 10'h000;
            r_ior_sync <= 3'b111;
            r_iow_sync <= 3'b111;
            r_prr_sync <= 3'b111;
            r_cx1_sync <= 3'b111;
            r_zk4_sync <= 2'b11;
        end else begin
            if (isa_ale) begin
                r_addr_q <= isa_addr;
            end
            r_ior_sync <= {r_ior_sync[1:0], isa_ior};
            r_iow_sync <= {r_iow_sync[1:0], isa_iow};
            r_prr_sync <= {r_prr_sync[1:0], cb_prr};
            r_cx1_sync <= {r_cx1_sync[1:0], cb_cx1};
            r_zk4_sync <= {r_zk4_sync[0], cb_zk4};
        end
    end

    // Read data mux for the register window
    always_comb begin
        w_rd_data = 8'h00;
        case (w_off)
            OFF_DATA_LO: w_rd_data = r_rx[7:0];
            OFF_DATA_HI: w_rd_data = r_rx[15:8];
            OFF_STATUS:  w_rd_data = {4'h0, r_tx_drive, r_zk4_sync[1], r_valid, r_prr_pending};
            OFF_CONTROL: w_rd_data = {6'h00, w_irq_en, r_tx_drive};
            default:     w_rd_data = 8'h00;
        endcase
    end

    assign isa_data = (w_sel && !isa_ior) ? w_rd_data : 8'hzz;
    assign cb_data  = r_tx_drive ? r_tx : 16'hzzzz;

    // Host-writable tx word and tx_drive
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_tx       <= 16'h0000;
            r_tx_drive <= 1'b0;
        end else if (w_wr) begin
            case (w_off)
                OFF_DATA_LO: r_tx[7:0]  <= isa_data;
                OFF_DATA_HI: r_tx[15:8] <= isa_data;
                OFF_CONTROL: r_tx_drive <= isa_data[0];
                default:     r_tx       <= r_tx;
            endcase
        end
    end

    // CAMAC receive latch; Z clear overrides a concurrent strobe
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_rx    <= 16'h0000;
            r_valid <= 1'b0;
        end else if (w_zk4_low) begin
            r_rx    <= 16'h0000;
            r_valid <= 1'b0;
        end else if (w_cx1_fall) begin
            r_rx    <= cb_data;
            r_valid <= 1'b1;
        end else if (w_rd_done && (w_off == OFF_DATA_HI)) begin
            r_valid <= 1'b0;
        end
    end

    // LAM pending flag: a new request beats a same-cycle ACK
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_prr_pending <= 1'b0;
        end else if (w_zk4_low) begin
            r_prr_pending <= 1'b0;
        end else if (w_prr_fall) begin
            r_prr_pending <= 1'b1;
        end else if (w_wr && (w_off == OFF_ACK)) begin
            r_prr_pending <= 1'b0;
        end
    end

    // Wait-state countdown; a new strobe reloads it
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if ((w_ior_fall || w_iow_fall) && w_sel) begin
            w_wait_nxt = WAIT_LOAD;
        end else if (r_wait_cnt != 4'd0) begin
            w_wait_nxt = r_wait_cnt - 4'd1;
        end else begin
            w_wait_nxt = r_wait_cnt;
        end
    end

    // Registered CHRDY and IRQ outputs
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_wait_cnt <= 4'd0;
            r_chrdy    <= 1'b1;
            r_irq      <= 8'h00;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            r_chrdy    <= (w_wait_nxt == 4'd0);
            r_irq      <= (w_irq_en && r_prr_pending) ? IRQ_MASK : 8'h00;
        end
    end

    assign isa_chrdy = r_chrdy;
    assign isa_irq   = r_irq;

endmodule

// File: tb/tb_sm2201_interface_board.sv
// Directed bench for sm2201_interface_board; released buses are pulled up so "Z" reads as all ones.
module tb_sm2201_interface_board;

    logic        isa_clk;
    logic        isa_reset;
    logic        isa_ior;
    logic        isa_iow;
    logic [9:0]  isa_addr;
    logic        isa_ale;
    logic        isa_aen;
    tri1  [7:0]  isa_data;
    logic        isa_chrdy;
    logic [7:0]  isa_irq;
    logic        cb_prr;
    logic        cb_zk4;
    logic        cb_cx1;
    tri1  [15:0] cb_data;

    logic        tb_isa_oe;
    logic [7:0]  tb_isa_drv;
    logic        tb_cb_oe;
    logic [15:0] tb_cb_drv;

    int          n_cmp;
    int          n_fail;
    logic [7:0]  rd;
    int          waits;
    logic [7:0]  exp_irq;
    logic [7:0]  exp_ctrl;

    assign isa_data = tb_isa_oe ? tb_isa_drv : 8'hzz;
    assign cb_data  = tb_cb_oe ? tb_cb_drv : 16'hzzzz;

    sm2201_interface_board dut (
        .isa_clk   (isa_clk),
        .isa_reset (isa_reset),
        .isa_ior   (isa_ior),
        .isa_iow   (isa_iow),
        .isa_addr  (isa_addr),
        .isa_ale   (isa_ale),
        .isa_aen   (isa_aen),
        .isa_data  (isa_data),
        .isa_chrdy (isa_chrdy),
        .isa_irq   (isa_irq),
        .cb_prr    (cb_prr),
        .cb_zk4    (cb_zk4),
        .cb_cx1    (cb_cx1),
        .cb_data   (cb_data)
    );

    initial isa_clk = 1'b0;
    always #5 isa_clk = ~isa_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge isa_clk);
    endtask

    task automatic latch(input logic [9:0] a);
        isa_addr = a;
        isa_ale  = 1'b1;
        tick(1);
        isa_ale  = 1'b0;
    endtask

    task automatic isa_read(input logic [9:0] a, input logic aen, output logic [7:0] d, output int w);
        latch(a);
        isa_aen = aen;
        isa_ior = 1'b0;
        tick(1);
        d = isa_data;
        w = 0;
        for (int i = 0; i < 8; i++) begin
            if (!isa_chrdy) w++;
            tick(1);
        end
        isa_ior = 1'b1;
        tick(4);
        isa_aen = 1'b0;
    endtask

    task automatic isa_write(input logic [9:0] a, input logic aen, input logic [7:0] d, output int w);
        latch(a);
        isa_aen    = aen;
        tb_isa_drv = d;
        tb_isa_oe  = 1'b1;
        isa_iow    = 1'b0;
        w = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (!isa_chrdy) w++;
        end
        isa_iow = 1'b1;
        tick(4);
        tb_isa_oe = 1'b0;
        isa_aen   = 1'b0;
    endtask

    task automatic cx1_pulse(input logic [15:0] v);
        tb_cb_drv = v;
        tb_cb_oe  = 1'b1;
        cb_cx1    = 1'b0;
        tick(4);
        cb_cx1    = 1'b1;
        tick(2);
        tb_cb_oe  = 1'b0;
        tick(1);
    endtask

    task automatic prr_pulse();
        cb_prr = 1'b0;
        tick(4);
        cb_prr = 1'b1;
        tick(3);
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        isa_reset  = 1'b0;
        isa_ior    = 1'b1;
        isa_iow    = 1'b1;
        isa_addr   = 10'h100;
        isa_ale    = 1'b0;
        isa_aen    = 1'b0;
        cb_prr     = 1'b1;
        cb_zk4     = 1'b1;
        cb_cx1     = 1'b1;
        tb_isa_oe  = 1'b0;
        tb_isa_drv = 8'h00;
        tb_cb_oe   = 1'b0;
        tb_cb_drv  = 16'h0000;
`ifdef SM2201_IRQ_EN
        exp_irq  = 8'h20;
        exp_ctrl = 8'h02;
`else
        exp_irq  = 8'h00;
        exp_ctrl = 8'h00;
`endif
        tick(3);
        check("rst_chrdy", {15'd0, isa_chrdy}, 16'h0001);
        check("rst_irq", {8'h00, isa_irq}, 16'h0000);
        check("rst_isa_data_z", {8'h00, isa_data}, 16'h00FF);
        check("rst_cb_data_z", cb_data, 16'hFFFF);

        isa_reset = 1'b1;
        latch(10'h100);
        tick(2);
        check("idle_chrdy", {15'd0, isa_chrdy}, 16'h0001);
        check("idle_irq", {8'h00, isa_irq}, 16'h0000);
        check("idle_isa_data_z", {8'h00, isa_data}, 16'h00FF);
        check("idle_cb_data_z", cb_data, 16'hFFFF);

        cx1_pulse(16'h4208);
        isa_read(10'h102, 1'b0, rd, waits);
        check("status_valid", {8'h00, rd}, 16'h0006);
        isa_read(10'h100, 1'b0, rd, waits);
        check("data_lo", {8'h00, rd}, 16'h0008);
        check("data_lo_waits", 16'(waits), 16'd2);
        isa_read(10'h101, 1'b0, rd, waits);
        check("data_hi", {8'h00, rd}, 16'h0042);
        check("data_hi_waits", 16'(waits), 16'd2);
        isa_read(10'h102, 1'b0, rd, waits);
        check("status_valid_cleared", {8'h00, rd}, 16'h0004);

        isa_write(10'h100, 1'b0, 8'h55, waits);
        check("write_waits", 16'(waits), 16'd2);
        isa_write(10'h101, 1'b0, 8'hAA, waits);
        isa_write(10'h103, 1'b0, 8'h01, waits);
        tick(1);
        check("cb_data_tx", cb_data, 16'hAA55);
        isa_read(10'h103, 1'b0, rd, waits);
        check("control_tx_drive", {8'h00, rd}, 16'h0001);
        isa_read(10'h102, 1'b0, rd, waits);
        check("status_tx_drive", {8'h00, rd}, 16'h000C);

        isa_write(10'h103, 1'b0, 8'h02, waits);
        tick(1);
        check("cb_data_released", cb_data, 16'hFFFF);
        prr_pulse();
        check("irq_raised", {8'h00, isa_irq}, {8'h00, exp_irq});
        isa_read(10'h102, 1'b0, rd, waits);
        check("status_prr", {8'h00, rd}, 16'h0005);
        isa_read(10'h103, 1'b0, rd, waits);
        check("control_irq_en", {8'h00, rd}, {8'h00, exp_ctrl});
        isa_write(10'h104, 1'b0, 8'h00, waits);
        tick(2);
        check("irq_acked", {8'h00, isa_irq}, 16'h0000);
        isa_read(10'h102, 1'b0, rd, waits);
        check("status_acked", {8'h00, rd}, 16'h0004);
        isa_read(10'h104, 1'b0, rd, waits);
        check("ack_reads_zero", {8'h00, rd}, 16'h0000);

        cx1_pulse(16'h1234);
        prr_pulse();
        isa_read(10'h102, 1'b0, rd, waits);
        check("status_before_clear", {8'h00, rd}, 16'h0007);
        cb_zk4 = 1'b0;
        tick(4);
        isa_read(10'h102, 1'b0, rd, waits);
        check("status_in_clear", {8'h00, rd}, 16'h0000);
        isa_read(10'h100, 1'b0, rd, waits);
        check("data_lo_cleared", {8'h00, rd}, 16'h0000);
        isa_read(10'h101, 1'b0, rd, waits);
        check("data_hi_cleared", {8'h00, rd}, 16'h0000);
        cb_zk4 = 1'b1;
        tick(4);
        isa_read(10'h102, 1'b0, rd, waits);
        check("status_after_clear", {8'h00, rd}, 16'h0004);

        for (int a = 5; a <= 62; a++) begin
            isa_read(10'h100 + 10'(a), 1'b0, rd, waits);
            check("sweep_reserved", {8'h00, rd}, 16'h0000);
        end

        isa_read(10'h140, 1'b0, rd, waits);
        check("outside_data_z", {8'h00, rd}, 16'h00FF);
        check("outside_waits", 16'(waits), 16'd0);
        isa_read(10'h100, 1'b1, rd, waits);
        check("aen_data_z", {8'h00, rd}, 16'h00FF);
        check("aen_waits", 16'(waits), 16'd0);
        isa_write(10'h103, 1'b1, 8'h01, waits);
        check("aen_write_waits", 16'(waits), 16'd0);
        check("aen_write_ignored", cb_data, 16'hFFFF);
        isa_write(10'h143, 1'b0, 8'h01, waits);
        check("outside_write_ignored", cb_data, 16'hFFFF);

        isa_write(10'h103, 1'b0, 8'h01, waits);
        tick(1);
        check("tx_kept", cb_data, 16'hAA55);
        isa_reset = 1'b0;
        #1;
        check("async_rst_cb_z", cb_data, 16'hFFFF);
        check("async_rst_chrdy", {15'd0, isa_chrdy}, 16'h0001);
        tick(2);
        isa_reset = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sm2201_interface_board.md
Name: sm2201_interface_board

Overview:
- Bridges the 8-bit ISA I/O bus of a PC to the SM2201 CAMAC crate controller's 16-bit data bus.
- Decodes a 64-byte I/O window (0x100–0x13F) into a small register file: CAMAC data word, status, control and IRQ acknowledge.
- Inserts ISA wait states via CHRDY.
- Captures CAMAC strobe, clear and request events, and optionally raises an ISA IRQ.

Parameters:
- BASE_ADDR, 10'h100, ISA I/O window base; window size fixed at 64 bytes (addr[9:6] compared).
- WAIT_STATES, 2, number of isa_clk cycles CHRDY is held low per access (legal range 0–15).
- IRQ_LINE, 5, index of the isa_irq bit driven by the request logic (0–7).

Ports:
- isa_clk  in  1  ISA bus clock; all logic synchronous to its rising edge.
- isa_reset  in  1  asynchronous, active-low reset.
- isa_ior  in  1  ISA I/O read strobe, active low.
- isa_iow  in  1  ISA I/O write strobe, active low.
- isa_addr  in  10  ISA I/O address.
- isa_ale  in  1  address latch enable, active high.
- isa_aen  in  1  DMA address enable; decode only when 0.
- isa_data  inout  8  ISA data bus; tri-stated unless a read is in progress.
- isa_chrdy  out  1  channel ready; 0 inserts wait states.
- isa_irq  out  8  ISA interrupt lines, active high.
- cb_prr  in  1  CAMAC request (LAM), active low, asynchronous.
- cb_zk4  in  1  CAMAC clear (Z), active low, asynchronous.
- cb_cx1  in  1  CAMAC data strobe, active low, asynchronous.
- cb_data  inout  16  CAMAC data bus.

Behaviour:
- Reset (isa_reset=0, async) clears the following:
  - rx latch, tx register and control go to 0; all pending flags go to 0.
  - addr_q goes to 0; isa_chrdy=1; isa_irq=0.
  - isa_data and cb_data go to Z.
- Address latch: addr_q <= isa_addr on every clock while isa_ale=1; held while isa_ale=0.
- sel = (isa_aen==0) && (addr_q[9:6]==BASE_ADDR[9:6]); off = addr_q[5:0].
- isa_ior, isa_iow and cb_* inputs each pass through a 2-flop synchronizer; edges are detected on the synchronized copies.
- Register map (off):
  - 0x00 DATA_LO: R = rx[7:0]; W = tx[7:0].
  - 0x01 DATA_HI: R = rx[15:8]; the read clears the valid flag. W = tx[15:8].
  - 0x02 STATUS (R only): bit0 prr_pending, bit1 valid, bit2 synchronized cb_zk4 level, bit3 tx_drive, bits7:4 = 0.
  - 0x03 CONTROL (R/W): bit0 tx_drive (enables cb_data output), bit1 irq_en, bits7:2 read 0.
  - 0x04 ACK (W only): any write clears prr_pending; reads 0.
  - 0x05–0x3F: read 0x00, writes ignored.
- Read: while sel && isa_ior==0, isa_data is driven combinationally from the selected register; otherwise Z.
- Write: on the synchronized rising edge of isa_iow with sel, the register at off takes isa_data.
- CHRDY:
  - On a synchronized falling edge of isa_ior or isa_iow with sel, isa_chrdy goes 0 for WAIT_STATES clocks, then returns to 1.
  - WAIT_STATES=0 leaves isa_chrdy at 1.
  - A new strobe during the count restarts it.
- CAMAC data capture: on the cb_cx1 falling edge, rx <= cb_data (sampled in the same cycle) and valid=1.
- CAMAC clear: while cb_zk4 is low, rx=0, valid=0 and prr_pending=0; this has priority over capture and request.
- CAMAC request: a cb_prr falling edge sets prr_pending. If the set and an ACK write occur in the same cycle, the set wins.
- cb_data is driven with tx when tx_drive=1, else Z.
- Strobes with isa_aen=1 or outside the window cause no register change and no CHRDY activity.
- Simultaneous ior and iow low is illegal; the read path still drives isa_data and the write still occurs.

Optional Feature:
- Macro SM2201_IRQ_EN.
  - Defined: isa_irq[IRQ_LINE] = irq_en & prr_pending; all other isa_irq bits are 0.
  - Undefined: isa_irq is constant 0, CONTROL bit1 reads 0 and ignores writes, and prr_pending stays visible in STATUS for polling.

Test Plan:
- Reset, then idle (ior=iow=1, addr 0x100) -> isa_chrdy=1, isa_irq=0, isa_data=Z, cb_data=Z.
- cb_data=16'h4208, cb_cx1 pulsed low; ALE latches 0x100, ior low -> isa_data=0x08 and CHRDY low 2 clocks; read 0x101 -> 0x42; read 0x102 -> bit1=0.
- Write 0x55 to 0x100, 0xAA to 0x101, 0x01 to 0x103; bench releases cb_data -> cb_data=16'hAA55.
- cb_prr falling edge with CONTROL=0x02 and SM2201_IRQ_EN defined -> isa_irq[5]=1, STATUS bit0=1; write 0x00 to 0x104 -> isa_irq=0.
- cb_zk4 low after a capture -> STATUS=0x00 (bit2=0), read 0x100 -> 0x00.
- Sweep reads 0x100–0x13E plus one at 0x140 and one with aen=1 -> offsets 0x05–0x3E return 0x00; 0x140 and the aen=1 access leave isa_data=Z and isa_chrdy=1.
